rvmyth_prefetch: RTL

Instruction prefetch unit that sits directly upstream of the rvmyth IF/ID register. It replaces the core's combinational instruction ROM read with a request/response instruction-memory port. Fetched words are buffered in a small in-order FIFO together with their PC. On a pipeline redirect (taken branch, jal, jalr) it flushes buffered and in-flight instructions and restarts fetch at the new PC.

---
 rtl/rvmyth_prefetch.sv | 73 +++++++
 1 files changed

// File: rtl/rvmyth_prefetch.sv
// rvmyth_prefetch: instruction prefetch with a request/response memory port, an in-order {pc,instr} FIFO and redirect flush.
module rvmyth_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [31:0]   pc_mem [FIFO_DEPTH];
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [CW:0]   used;
  logic          req_hs, push, pop;
  // Stale requests still hold credits, so a full drain can never overflow the FIFO.
  assign used          = {1'b0, cnt_q} + {1'b0, outst_q};
  assign mem_req_valid = rst_n && (used < (CW+1)'(FIFO_DEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign req_hs        = mem_req_valid && mem_req_ready;
  assign out_valid     = cnt_q != '0;
  assign pop           = out_valid && out_ready;
  assign push          = mem_rsp_valid && drop_q == '0 && !redirect_valid;
  assign out_pc        = out_valid ? pc_mem[rd_q] : '0;
  assign out_instr     = out_valid ? instr_mem[rd_q] : '0;
  always_comb begin
    outst_d    = outst_q + CW'(req_hs) - CW'(mem_rsp_valid);
    drop_d     = redirect_valid ? outst_d : drop_q - CW'(mem_rsp_valid && drop_q != '0);
    fetch_pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : fetch_pc_q + (req_hs ? 32'd4 : 32'd0);
    rsp_pc_d   = redirect_valid ? {redirect_pc[31:2], 2'b00} : rsp_pc_q + (push ? 32'd4 : 32'd0);
    cnt_d      = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
    wr_d       = wr_q + AW'(push);
    rd_d       = redirect_valid ? wr_q : rd_q + AW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]    <= rsp_pc_q;
      instr_mem[wr_q] <= mem_rsp_data;
    end
  end
endmodule
